// File: rtl/mem_arb_pkg.sv
// Shared types and tag helpers for the two-client memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WDATA
    } state_t;

    typedef logic client_id_t;

    // Build a memory-side tag by placing the client ID above the client-local tag.
    function automatic logic [31:0] mk_tag(input client_id_t id, input logic [31:0] tag,
                                           input int tag_bits);
        logic [31:0] id_bit;
        id_bit = {31'b0, id} << (tag_bits - 1);
        return id_bit | tag;
    endfunction

    // Recover the client ID from the top bit of a memory-side tag.
    function automatic client_id_t tag_id(input logic [31:0] tag, input int tag_bits);
        logic [31:0] shifted;
        shifted = tag >> (tag_bits - 1);
        return shifted[0];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, ties go to the client
// that did not win last time.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  client_id_t last_grant,
    output logic       any,
    output client_id_t grant
);

    // Combinational pick; the caller registers the result.
    always_comb begin
        any   = |valid;
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Shares one memory request/write-data port between the icache (client 0)
// and the dcache (client 1); responses are routed back by the tag's top bit.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS   = 28,
    parameter int DATA_BITS   = 128,
    parameter int TAG_BITS    = 5,
    parameter int WRITE_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   c0_req_valid,
    output logic                   c0_req_ready,
    input  logic                   c0_req_rw,
    input  logic [ADDR_BITS-1:0]   c0_req_addr,
    input  logic [TAG_BITS-2:0]    c0_req_tag,
    input  logic                   c0_req_data_valid,
    output logic                   c0_req_data_ready,
    input  logic [DATA_BITS-1:0]   c0_req_data_bits,
    input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
    output logic                   c0_resp_valid,
    output logic [TAG_BITS-2:0]    c0_resp_tag,
    output logic [DATA_BITS-1:0]   c0_resp_data,

    input  logic                   c1_req_valid,
    output logic                   c1_req_ready,
    input  logic                   c1_req_rw,
    input  logic [ADDR_BITS-1:0]   c1_req_addr,
    input  logic [TAG_BITS-2:0]    c1_req_tag,
    input  logic                   c1_req_data_valid,
    output logic                   c1_req_data_ready,
    input  logic [DATA_BITS-1:0]   c1_req_data_bits,
    input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
    output logic                   c1_resp_valid,
    output logic [TAG_BITS-2:0]    c1_resp_tag,
    output logic [DATA_BITS-1:0]   c1_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [TAG_BITS-1:0]    mem_resp_tag,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int BEAT_W = (WRITE_BEATS > 1) ? $clog2(WRITE_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WRITE_BEATS - 1);

    state_t            state, state_next;
    client_id_t        grant, grant_next;
    client_id_t        last_grant, last_grant_next;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_next;

    logic              arb_any;
    client_id_t        arb_grant;

    logic                   g_req_valid;
    logic                   g_req_rw;
    logic [ADDR_BITS-1:0]   g_req_addr;
    logic [TAG_BITS-2:0]    g_req_tag;
    logic                   g_data_valid;
    logic [DATA_BITS-1:0]   g_data_bits;
    logic [DATA_BITS/8-1:0] g_data_mask;

    rr_arbiter2 u_rr (
        .valid      ({c1_req_valid, c0_req_valid}),
        .last_grant (last_grant),
        .any        (arb_any),
        .grant      (arb_grant)
    );

    assign g_req_valid  = grant ? c1_req_valid      : c0_req_valid;
    assign g_req_rw     = grant ? c1_req_rw         : c0_req_rw;
    assign g_req_addr   = grant ? c1_req_addr       : c0_req_addr;
    assign g_req_tag    = grant ? c1_req_tag        : c0_req_tag;
    assign g_data_valid = grant ? c1_req_data_valid : c0_req_data_valid;
    assign g_data_bits  = grant ? c1_req_data_bits  : c0_req_data_bits;
    assign g_data_mask  = grant ? c1_req_data_mask  : c0_req_data_mask;

    // Responses carry no backpressure, so route them straight through by tag ID.
    assign c0_resp_valid = mem_resp_valid & (tag_id(32'(mem_resp_tag), TAG_BITS) == 1'b0);
    assign c1_resp_valid = mem_resp_valid & (tag_id(32'(mem_resp_tag), TAG_BITS) == 1'b1);
    assign c0_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    assign c1_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    assign c0_resp_data  = mem_resp_data;
    assign c1_resp_data  = mem_resp_data;

    // State, grant and beat registers; client 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            beat_cnt   <= beat_cnt_next;
        end
    end

    // Next-state logic and port muxing; only the granted client ever sees a ready.
    always_comb begin
        state_next         = state;
        grant_next         = grant;
        last_grant_next    = last_grant;
        beat_cnt_next      = beat_cnt;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        c0_req_ready       = 1'b0;
        c1_req_ready       = 1'b0;
        c0_req_data_ready  = 1'b0;
        c1_req_data_ready  = 1'b0;

        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_next = arb_grant;
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req_valid = g_req_valid;
                mem_req_rw    = g_req_rw;
                mem_req_addr  = g_req_addr;
                mem_req_tag   = TAG_BITS'(mk_tag(grant, 32'(g_req_tag), TAG_BITS));
                if (grant) begin
                    c1_req_ready = mem_req_ready;
                end else begin
                    c0_req_ready = mem_req_ready;
                end
                if (g_req_valid && mem_req_ready) begin
                    last_grant_next = grant;
                    if (g_req_rw) begin
                        beat_cnt_next = '0;
                        state_next    = WDATA;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            WDATA: begin
                mem_req_data_valid = g_data_valid;
                mem_req_data_bits  = g_data_bits;
                mem_req_data_mask  = g_data_mask;
                if (grant) begin
                    c1_req_data_ready = mem_req_data_ready;
                end else begin
                    c0_req_data_ready = mem_req_data_ready;
                end
                if (g_data_valid && mem_req_data_ready) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_next = '0;
                        state_next    = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Shares the single core-to-memory port between two clients: client 0 (icache refill) and client 1 (dcache refill/writeback).
- Arbitrates request-channel ownership round-robin and sequences multi-beat write data for the granted client.
- Prefixes each outgoing tag with the client ID so that responses, which carry no backpressure, route back combinationally.
- Sits between the cache controllers and the memory interface bundle.

Parameters:
- ADDR_BITS, 28, memory request address width (equals MEM_ADDR_BITS).
- DATA_BITS, 128, data beat width (equals MEM_DATA_BITS).
- TAG_BITS, 5, memory-side tag width (equals MEM_TAG_BITS); client tags are TAG_BITS-1 wide.
- WRITE_BEATS, 4, data beats per write request; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- c{0,1}_req_valid / c{0,1}_req_ready  in / out  1  client request handshake.
- c{0,1}_req_rw  in  1  1 = write, 0 = read.
- c{0,1}_req_addr  in  ADDR_BITS  request address.
- c{0,1}_req_tag  in  TAG_BITS-1  client-local tag.
- c{0,1}_req_data_valid / c{0,1}_req_data_ready  in / out  1  client write-data handshake.
- c{0,1}_req_data_bits  in  DATA_BITS  write data beat.
- c{0,1}_req_data_mask  in  DATA_BITS/8  byte enables.
- c{0,1}_resp_valid  out  1  response valid for this client.
- c{0,1}_resp_tag  out  TAG_BITS-1  response tag, ID bit stripped.
- c{0,1}_resp_data  out  DATA_BITS  response data.
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
- mem_req_rw  out  1  forwarded rw.
- mem_req_addr  out  ADDR_BITS  forwarded address.
- mem_req_tag  out  TAG_BITS  {client_id, client_tag}.
- mem_req_data_valid / mem_req_data_ready  out / in  1  memory write-data handshake.
- mem_req_data_bits  out  DATA_BITS  forwarded data beat.
- mem_req_data_mask  out  DATA_BITS/8  forwarded byte enables.
- mem_resp_valid  in  1  response valid.
- mem_resp_tag  in  TAG_BITS  response tag.
- mem_resp_data  in  DATA_BITS  response data.

Behaviour:
- Reset (async, immediate):
  - State IDLE, grant = 0, last_grant = 1 so client 0 wins first, beat_cnt = 0.
  - All ready and valid outputs are 0; mem_req_* data/addr outputs are 0.
- FSM states: IDLE, REQ, WDATA.
- IDLE:
  - If any c*_req_valid, latch grant: the sole requester, or when both request, the client != last_grant. Go to REQ.
  - No client ready is asserted in IDLE.
  - Minimum latency is 1 cycle from client valid to mem_req_valid.
- REQ:
  - mem_req_valid = granted client's req_valid; rw/addr/tag are muxed from the granted client.
  - c[g]_req_ready = mem_req_ready; the other client's ready is 0.
  - On handshake: last_grant <= g. If rw = 0, go to IDLE. If rw = 1, set beat_cnt = 0 and go to WDATA.
  - Clients must hold valid and payload stable until ready; the arbiter does not re-arbitrate while in REQ.
- WDATA:
  - mem_req_data_valid = c[g]_req_data_valid; c[g]_req_data_ready = mem_req_data_ready; bits and mask are muxed from client g.
  - Each handshake increments beat_cnt. The handshake with beat_cnt == WRITE_BEATS-1 returns to IDLE.
  - The non-granted client's data_ready is always 0.
  - Request readies are 0 in WDATA; a pending request from the other client waits.
- Data channel outside WDATA: both data readies are 0 and mem_req_data_valid is 0. Clients send write data only after their request is accepted.
- Responses (combinational, independent of the FSM, active in every state):
  - c0_resp_valid = mem_resp_valid & ~mem_resp_tag[TAG_BITS-1].
  - c1_resp_valid = mem_resp_valid & mem_resp_tag[TAG_BITS-1].
  - resp_tag = mem_resp_tag[TAG_BITS-2:0]; resp_data = mem_resp_data, broadcast to both clients.
- Fairness: strict alternation when both clients continuously request; a lone requester is served back-to-back.
- Reset mid-transaction: the transaction is abandoned and outputs drop the same cycle. Memory-side consistency is not guaranteed and is not checked.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, REQ, WDATA};
  - client_id_t (1 bit);
  - helpers mk_tag(id, tag) and tag_id(tag).
- Sub-module rr_arbiter2: 2-way round-robin pick from (valid[1:0], last_grant) to grant. Combinational; its result is registered in mem_arbiter2.

Test Plan:
- Reset, then c0 read addr 0x100 tag 3 -> mem_req_valid rises one cycle later, mem_req_tag = 5'b00011, rw = 0. With mem_req_ready = 1, c0_req_ready pulses for 1 cycle.
- c0 and c1 read continuously, each holding valid with mem_req_ready = 1 -> accepted order c0, c1, c0, c1; tags alternate MSB 0/1.
- c1 write (WRITE_BEATS = 4) while c0 requests, mem_req_data_ready toggling 1,0,1,0 -> 4 beats forwarded in order with masks intact. c0 is not granted until the cycle after the 4th beat.
- mem_resp_valid with tag 5'b10010, data 0xDEAD during c0 traffic -> c1_resp_valid = 1 with tag 4'b0010 and data 0xDEAD; c0_resp_valid = 0.
- mem_req_ready held 0 for 5 cycles in REQ -> mem_req_valid stays 1, addr and tag stable, client ready stays 0. Handshake completes on the cycle ready rises.
- Reset asserted mid-cycle after 2 of 4 write beats -> all valid and ready outputs are 0 immediately. After release, simultaneous requests grant c0 first.
